// File: rtl/sdram_wb_bridge.sv
// Bus-side responder for the SDRAM controller core: launches requests, drives DQM,
// captures read data and returns a delayed acknowledge. Optional watchdog: SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_wb_bridge #(
    parameter int ADDR_W         = 21,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [1:0]        wb_sel,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    output logic              wb_ack,
    output logic              wb_err,
    input  logic              sdram_init_done,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic [ADDR_W:0]   sdram_addr,
    output logic [15:0]       sdram_wdata,
    input  logic [15:0]       sdram_rdata,
    output logic [1:0]        sdram_byteenable,
    output logic              dqm_h,
    output logic              dqm_l
);

    // DRAIN is reserved and shares the IDLE encoding, so it needs no constant of its own.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DLY  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              we_q, we_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic              dqm_h_q, dqm_h_d;
    logic              dqm_l_q, dqm_l_d;
    logic              dly_q, dly_d;
    logic              ack_hit;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    assign ack_hit = we_q ? sdram_wr_ack : sdram_rd_ack;

    // DLY dwells two clocks so wb_ack lands two clocks after the controller ack.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wr_req_d = wr_req_q;
        rd_req_d = rd_req_q;
        dqm_h_d  = dqm_h_q;
        dqm_l_d  = dqm_l_q;
        dly_d    = 1'b0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (wb_stb && sdram_init_done) begin
                    adr_d   = wb_adr;
                    we_d    = wb_we;
                    sel_d   = wb_sel;
                    wdata_d = wb_dat_i;
                    dqm_h_d = wb_we & ~wb_sel[1];
                    dqm_l_d = wb_we & ~wb_sel[0];
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
                    cnt_d   = 10'd0;
                    err_d   = 1'b0;
`endif
                    if (wb_we && (wb_sel == 2'b00)) begin
                        state_d = S_DLY;
                    end else begin
                        state_d  = S_REQ;
                        wr_req_d = wb_we;
                        rd_req_d = ~wb_we;
                    end
                end
            end
            S_REQ: begin
                if (ack_hit) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = sdram_rdata;
                    end
                    state_d = wb_stb ? S_DLY : S_IDLE;
                end
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = 16'hFFFF;
                    end
                    err_d   = 1'b1;
                    state_d = S_DLY;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
`endif
            end
            S_DLY: begin
                dly_d = 1'b1;
                if (dly_q) begin
                    dly_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!wb_stb) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 2'b00;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            dqm_h_q  <= 1'b0;
            dqm_l_q  <= 1'b0;
            dly_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            dqm_h_q  <= dqm_h_d;
            dqm_l_q  <= dqm_l_d;
            dly_q    <= dly_d;
        end
    end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 10'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign wb_err = err_q;
`else
    assign wb_err = 1'b0;
`endif

    // wb_ack follows the strobe combinationally so it falls in the clock the master releases.
    assign wb_ack           = wb_stb && (state_q == S_DONE);
    assign wb_dat_o         = rdata_q;
    assign sdram_wr_req     = wr_req_q;
    assign sdram_rd_req     = rd_req_q;
    assign sdram_addr       = {1'b0, adr_q};
    assign sdram_wdata      = wdata_q;
    assign sdram_byteenable = sel_q;
    assign dqm_h            = dqm_h_q;
    assign dqm_l            = dqm_l_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Scoreboard bench for sdram_wb_bridge; covers the watchdog when SDRAM_BRIDGE_TIMEOUT_EN is defined.
module tb_sdram_wb_bridge;

    localparam int ADDR_W = 21;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_stb;
    logic              wb_we;
    logic [1:0]        wb_sel;
    logic [ADDR_W-1:0] wb_adr;
    logic [15:0]       wb_dat_i;
    logic [15:0]       wb_dat_o;
    logic              wb_ack;
    logic              wb_err;
    logic              sdram_init_done;
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic              sdram_wr_ack;
    logic              sdram_rd_ack;
    logic [ADDR_W:0]   sdram_addr;
    logic [15:0]       sdram_wdata;
    logic [15:0]       sdram_rdata;
    logic [1:0]        sdram_byteenable;
    logic              dqm_h;
    logic              dqm_l;

    exp_t        sb[$];
    exp_t        mon_exp;
    logic        ack_prev = 1'b0;
    logic [15:0] model_dat;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    sdram_wb_bridge #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wb_stb(wb_stb),
        .wb_we(wb_we),
        .wb_sel(wb_sel),
        .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack(wb_ack),
        .wb_err(wb_err),
        .sdram_init_done(sdram_init_done),
        .sdram_wr_req(sdram_wr_req),
        .sdram_rd_req(sdram_rd_req),
        .sdram_wr_ack(sdram_wr_ack),
        .sdram_rd_ack(sdram_rd_ack),
        .sdram_addr(sdram_addr),
        .sdram_wdata(sdram_wdata),
        .sdram_rdata(sdram_rdata),
        .sdram_byteenable(sdram_byteenable),
        .dqm_h(dqm_h),
        .dqm_l(dqm_l)
    );

    // Each rising wb_ack retires the oldest outstanding bus cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            ack_prev = 1'b0;
        end else begin
            if (wb_ack && !ack_prev) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL sb_unexpected_ack: wb_ack=1 with nothing outstanding, required no ack");
                end else begin
                    mon_exp = sb.pop_front();
                    if ({wb_dat_o, wb_err} !== {mon_exp.data, mon_exp.err}) begin
                        tests_failed++;
                        $display("[TB] FAIL sb_ack_data: dat_o=%h err=%b, required dat_o=%h err=%b",
                                 wb_dat_o, wb_err, mon_exp.data, mon_exp.err);
                    end
                end
            end
            ack_prev = wb_ack;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle(input logic we, input logic [1:0] sel,
                               input logic [ADDR_W-1:0] adr, input logic [15:0] dat);
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_sel   = sel;
        wb_adr   = adr;
        wb_dat_i = dat;
        tick();
    endtask

    task automatic pulse_ack(input logic we, input logic [15:0] rdata);
        if (we) begin
            sdram_wr_ack = 1'b1;
            sdram_rdata  = 16'($urandom);
        end else begin
            sdram_rd_ack = 1'b1;
            sdram_rdata  = rdata;
        end
        tick();
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        sdram_rdata  = 16'($urandom);
    endtask

    task automatic wait_ack(input int limit, output int cycles, output bit seen, output bit req_seen);
        cycles   = 0;
        seen     = 1'b0;
        req_seen = 1'b0;
        while (!seen && cycles < limit) begin
            tick();
            cycles++;
            if (sdram_rd_req || sdram_wr_req) req_seen = 1'b1;
            seen = wb_ack;
        end
    endtask

    task automatic end_cycle();
        @(negedge clk);
        #1;
        wb_stb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({sdram_wr_req, sdram_rd_req, wb_ack, wb_err, wb_dat_o, dqm_h, dqm_l,
             sdram_addr, sdram_wdata, sdram_byteenable} !== 62'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: wr=%b rd=%b ack=%b err=%b dat=%h dqm=%b%b addr=%h wdata=%h be=%b, required all 0",
                     sdram_wr_req, sdram_rd_req, wb_ack, wb_err, wb_dat_o, dqm_h, dqm_l,
                     sdram_addr, sdram_wdata, sdram_byteenable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        model_dat = 16'h0000;
    endtask

    task automatic test_read();
        int cycles;
        bit seen, req_seen;
        start_cycle(1'b0, 2'b11, 21'h012345, 16'h0000);
        sb.push_back('{data: 16'hA5C3, err: 1'b0});
        tests_run++;
        if ({sdram_rd_req, sdram_wr_req, sdram_addr, dqm_h, dqm_l} !== {1'b1, 1'b0, 22'h012345, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL read_launch: rd=%b wr=%b addr=%h dqm=%b%b, required rd=1 wr=0 addr=012345 dqm=00",
                     sdram_rd_req, sdram_wr_req, sdram_addr, dqm_h, dqm_l);
        end
        repeat (4) tick();
        pulse_ack(1'b0, 16'hA5C3);
        tests_run++;
        if (sdram_rd_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_req_drop: rd_req=%b, required 0", sdram_rd_req);
        end
        wait_ack(8, cycles, seen, req_seen);
        tests_run++;
        if (!seen || cycles != 2) begin
            tests_failed++;
            $display("[TB] FAIL read_ack_delay: seen=%b after %0d clocks, required ack after 2", seen, cycles);
        end
        @(negedge clk);
        #1;
        wb_stb = 1'b0;
        #1;
        tests_run++;
        if (wb_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ack_follows_stb: wb_ack=%b after stb drop, required 0", wb_ack);
        end
        model_dat = 16'hA5C3;
        tick();
    endtask

    task automatic test_write();
        int cycles;
        bit seen, req_seen;
        start_cycle(1'b1, 2'b10, 21'h1ABCD, 16'h1234);
        sb.push_back('{data: model_dat, err: 1'b0});
        tests_run++;
        if ({sdram_wr_req, sdram_rd_req, dqm_h, dqm_l, sdram_wdata, sdram_byteenable}
            !== {1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 2'b10}) begin
            tests_failed++;
            $display("[TB] FAIL write_launch: wr=%b rd=%b dqm_h=%b dqm_l=%b wdata=%h be=%b, required 1 0 0 1 1234 10",
                     sdram_wr_req, sdram_rd_req, dqm_h, dqm_l, sdram_wdata, sdram_byteenable);
        end
        tick();
        sdram_rd_ack = 1'b1;
        sdram_rdata  = 16'hDEAD;
        tick();
        sdram_rd_ack = 1'b0;
        tests_run++;
        if (sdram_wr_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrong_type_ack: wr_req=%b after rd_ack in write, required 1", sdram_wr_req);
        end
        tick();
        pulse_ack(1'b1, 16'h0000);
        tests_run++;
        if (sdram_wr_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL write_req_drop: wr_req=%b, required 0", sdram_wr_req);
        end
        wait_ack(8, cycles, seen, req_seen);
        tests_run++;
        if (!seen || cycles != 2) begin
            tests_failed++;
            $display("[TB] FAIL write_ack_delay: seen=%b after %0d clocks, required ack after 2", seen, cycles);
        end
        end_cycle();
    endtask

    task automatic test_masked_write();
        int cycles;
        bit seen, req_seen;
        start_cycle(1'b1, 2'b00, 21'h00100, 16'h5555);
        sb.push_back('{data: model_dat, err: 1'b0});
        tests_run++;
        if ({sdram_wr_req, sdram_rd_req, dqm_h, dqm_l} !== 4'b0011) begin
            tests_failed++;
            $display("[TB] FAIL masked_launch: wr=%b rd=%b dqm=%b%b, required wr=0 rd=0 dqm=11",
                     sdram_wr_req, sdram_rd_req, dqm_h, dqm_l);
        end
        wait_ack(8, cycles, seen, req_seen);
        tests_run++;
        if (!seen || cycles != 2 || req_seen) begin
            tests_failed++;
            $display("[TB] FAIL masked_ack: seen=%b clocks=%0d req_seen=%b, required ack after 2 with no request",
                     seen, cycles, req_seen);
        end
        end_cycle();
    endtask

    task automatic test_init_wait();
        int cycles;
        int bad;
        bit seen, req_seen;
        bad = 0;
        sdram_init_done = 1'b0;
        start_cycle(1'b0, 2'b11, 21'h00777, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            if (sdram_rd_req || sdram_wr_req) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL init_hold: request seen in %0d clocks before init_done, required 0", bad);
        end
        sdram_init_done = 1'b1;
        tick();
        sb.push_back('{data: 16'h5A5A, err: 1'b0});
        tests_run++;
        if (sdram_rd_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL init_launch: rd_req=%b one clock after init_done, required 1", sdram_rd_req);
        end
        tick();
        pulse_ack(1'b0, 16'h5A5A);
        wait_ack(8, cycles, seen, req_seen);
        tests_run++;
        if (!seen || cycles != 2) begin
            tests_failed++;
            $display("[TB] FAIL init_ack: seen=%b after %0d clocks, required ack after 2", seen, cycles);
        end
        model_dat = 16'h5A5A;
        end_cycle();
    endtask

    task automatic test_abort();
        int cycles;
        bit seen, req_seen;
        start_cycle(1'b0, 2'b11, 21'h0F0F0, 16'h0000);
        tick();
        wb_stb = 1'b0;
        tick();
        tests_run++;
        if (sdram_rd_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_req_held: rd_req=%b after stb drop, required 1", sdram_rd_req);
        end
        pulse_ack(1'b0, 16'h1111);
        tests_run++;
        if ({sdram_rd_req, wb_dat_o} !== {1'b0, 16'h1111}) begin
            tests_failed++;
            $display("[TB] FAIL abort_capture: rd_req=%b dat_o=%h, required rd_req=0 dat_o=1111",
                     sdram_rd_req, wb_dat_o);
        end
        model_dat = 16'h1111;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = 21'h00042;
        #1;
        tests_run++;
        if (wb_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_ack: wb_ack=%b after aborted cycle, required 0", wb_ack);
        end
        tick();
        sb.push_back('{data: 16'h2222, err: 1'b0});
        tests_run++;
        if ({sdram_rd_req, wb_ack} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL abort_relaunch: rd_req=%b ack=%b, required rd_req=1 ack=0", sdram_rd_req, wb_ack);
        end
        pulse_ack(1'b0, 16'h2222);
        wait_ack(8, cycles, seen, req_seen);
        tests_run++;
        if (!seen || cycles != 2) begin
            tests_failed++;
            $display("[TB] FAIL abort_next_ack: seen=%b after %0d clocks, required ack after 2", seen, cycles);
        end
        model_dat = 16'h2222;
        end_cycle();
    endtask

    task automatic test_reset_in_req();
        start_cycle(1'b1, 2'b01, 21'h155AA, 16'hBEEF);
        tick();
        tests_run++;
        if ({sdram_wr_req, dqm_h, dqm_l} !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL rst_pre: wr=%b dqm=%b%b, required wr=1 dqm=10", sdram_wr_req, dqm_h, dqm_l);
        end
        #2;
        rst_n  = 1'b0;
        wb_stb = 1'b0;
        #1;
        tests_run++;
        if ({sdram_wr_req, sdram_rd_req, wb_ack, wb_err, wb_dat_o, dqm_h, dqm_l,
             sdram_addr, sdram_wdata, sdram_byteenable} !== 62'd0) begin
            tests_failed++;
            $display("[TB] FAIL rst_in_req: wr=%b rd=%b ack=%b err=%b dat=%h dqm=%b%b addr=%h wdata=%h be=%b, required all 0",
                     sdram_wr_req, sdram_rd_req, wb_ack, wb_err, wb_dat_o, dqm_h, dqm_l,
                     sdram_addr, sdram_wdata, sdram_byteenable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        model_dat = 16'h0000;
    endtask

    task automatic test_back_to_back();
        int cycles;
        bit seen, req_seen;
        logic we;
        logic [1:0] sel;
        logic [ADDR_W-1:0] adr;
        logic [15:0] dat, rd;
        int lat;
        for (int i = 0; i < 8; i++) begin
            we  = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(1, 3));
            adr = ADDR_W'($urandom);
            dat = 16'($urandom);
            rd  = 16'($urandom);
            lat = $urandom_range(0, 3);
            start_cycle(we, sel, adr, dat);
            tests_run++;
            if (sdram_addr !== {1'b0, adr} || (we && sdram_wdata !== dat)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_launch[%0d]: addr=%h wdata=%h, required addr=%h wdata=%h",
                         i, sdram_addr, sdram_wdata, {1'b0, adr}, dat);
            end
            if (!we) model_dat = rd;
            sb.push_back('{data: model_dat, err: 1'b0});
            repeat (lat) tick();
            pulse_ack(we, rd);
            wait_ack(8, cycles, seen, req_seen);
            tests_run++;
            if (!seen || cycles != 2) begin
                tests_failed++;
                $display("[TB] FAIL b2b_ack[%0d]: seen=%b after %0d clocks, required ack after 2", i, seen, cycles);
            end
            end_cycle();
        end
    endtask

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int cycles;
        int bad;
        bit seen, req_seen;
        bad = 0;
        start_cycle(1'b0, 2'b11, 21'h1FFFF, 16'h0000);
        sb.push_back('{data: 16'hFFFF, err: 1'b1});
        for (int i = 1; i < 16; i++) begin
            if (sdram_rd_req !== 1'b1) bad++;
            tick();
        end
        if (sdram_rd_req !== 1'b1) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_hold: rd_req low in %0d of first 16 clocks, required 0", bad);
        end
        tick();
        tests_run++;
        if ({sdram_rd_req, wb_err, wb_dat_o} !== {1'b0, 1'b1, 16'hFFFF}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_fire: rd=%b err=%b dat=%h, required rd=0 err=1 dat=ffff",
                     sdram_rd_req, wb_err, wb_dat_o);
        end
        wait_ack(8, cycles, seen, req_seen);
        tests_run++;
        if (!seen || cycles != 2) begin
            tests_failed++;
            $display("[TB] FAIL timeout_ack: seen=%b after %0d clocks, required ack after 2", seen, cycles);
        end
        end_cycle();
        start_cycle(1'b0, 2'b11, 21'h00003, 16'h0000);
        sb.push_back('{data: 16'h1357, err: 1'b0});
        tests_run++;
        if (wb_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_clear: wb_err=%b after new strobe, required 0", wb_err);
        end
        pulse_ack(1'b0, 16'h1357);
        wait_ack(8, cycles, seen, req_seen);
        model_dat = 16'h1357;
        end_cycle();
    endtask
`endif

    initial begin
        rst_n           = 1'b0;
        wb_stb          = 1'b0;
        wb_we           = 1'b0;
        wb_sel          = 2'b00;
        wb_adr          = '0;
        wb_dat_i        = 16'h0000;
        sdram_init_done = 1'b1;
        sdram_wr_ack    = 1'b0;
        sdram_rd_ack    = 1'b0;
        sdram_rdata     = 16'h0000;
        model_dat       = 16'h0000;

        test_reset();
        test_read();
        test_write();
        test_masked_write();
        test_init_wait();
        test_abort();
        test_reset_in_req();
        test_back_to_back();
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) tick();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL sb_drain: %0d cycles never acknowledged, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
